bcd_counter_ndigit: RTL
=======================

Name: bcd_counter_ndigit

Overview:
Registered, parametrised N-digit BCD up/down counter. It is the successor to the combinational 5-digit BCD incrementer and is used for score, uptime and event counters shown on the 12864 LCD. It adds a clock, count direction, synchronous clear and load, wrap or saturate mode, and registered carry/borrow and status flags. The output feeds the display formatter directly, with one packed BCD nibble per digit.

Parameters:
DIGITS, 5, number of BCD digits (1..8); digit 0 is the least significant, in bits [3:0].
WRAP, 1, 1 = wrap at the count limits; 0 = saturate at the count limits.

Ports:
clk  input  1  system clock, rising-edge active.
reset_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous clear to all zeros.
load  input  1  synchronous parallel load of load_value.
load_value  input  4*DIGITS  packed BCD value to load.
enable  input  1  count one step this cycle.
up  input  1  direction: 1 = increment, 0 = decrement; sampled only when enable=1.
count  output  4*DIGITS  registered packed BCD count.
carry  output  1  one-cycle pulse on overflow (up) or underflow (down).
at_max  output  1  count is all nines (combinational from count register).
at_min  output  1  count is all zeros (combinational from count register).
load_err  output  1  one-cycle pulse: load_value contained a non-BCD nibble.

Behaviour:
- Reset (reset_n=0, asynchronous): count=0, carry=0, load_err=0. Therefore at_min=1 and at_max=0.
- Release of reset is synchronised externally; the block samples inputs on the first rising edge with reset_n=1.
- Priority per cycle: clear > load > enable. Lower-priority inputs are ignored in a cycle where a higher-priority input is active.
- clear: count <= 0 next edge; carry=0, load_err=0.
- load: every nibble of load_value >9 is replaced with 0; valid nibbles are taken unchanged.
  - load_err=1 for exactly the following cycle if any nibble was replaced, else 0.
  - carry=0.
- enable with up=1: ripple increment, computed combinationally across all digits within one cycle.
  - Digit d increments if all lower digits are 9; each such lower digit becomes 0.
  - From all nines: WRAP=1 gives count=0 and carry=1. WRAP=0 holds all nines and gives carry=1.
- enable with up=0: ripple decrement.
  - Digit d decrements if all lower digits are 0; each such lower digit becomes 9.
  - From all zeros: WRAP=1 gives all nines and carry=1. WRAP=0 holds zero and gives carry=1.
- No enable, clear or load: count holds; carry=0; load_err=0.
- Latency: one cycle from input sample to count/carry/load_err update. carry is asserted in the same cycle the new (wrapped or held) count is visible.
- carry is a single-cycle pulse per overflow event. With continuous enable at the limit in saturate mode, carry pulses on every enabled cycle.
- A non-BCD nibble can never appear in count. The internal state only ever takes legal values, and loads are sanitised.
- Reset asserted mid-count: count zeroes immediately, without waiting for the next clock edge, and pending pulses are cleared.
- Width: count is exactly 4*DIGITS bits. No internal binary conversion; arithmetic is per-digit BCD.
- Target: single clock domain; the ripple chain must close timing at 50 MHz for DIGITS=8 on Cyclone-class parts.

Test Plan:
- Reset then increment: DIGITS=5, WRAP=1; reset, 12 enabled up cycles.
  -> count=0x00012; at_min=1 after reset only; carry never pulses.
- Multi-digit ripple up: load 0x09999, one up step.
  -> count=0x10000, carry=0. Then load 0x99999, one up step -> count=0x00000, carry=1 for one cycle, at_min=1.
- Decrement and borrow: load 0x10000, one down step.
  -> count=0x09999. Load 0x00000, one down step -> count=0x99999, carry=1, at_max=1.
- Saturate mode: WRAP=0, load 0x99998, three enabled up cycles.
  -> count 0x99999, then 0x99999, then 0x99999; carry=0,1,1. Mirror test from 0x00001 counting down.
- Priority and sanitising: clear=1, load=1 and enable=1 in the same cycle -> count=0. Then load 0x1A3F5 with enable=1 -> count=0x10305, load_err=1 for one cycle, no increment applied.
- Async reset mid-operation: count running at 0x00477 with enable=1; pulse reset_n low between clock edges.
  -> count=0 before the next edge, carry=0. Counting resumes from 0 at the first edge after release.

Source files
------------

// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: registered N-digit BCD up/down counter with wrap/saturate,
// synchronous clear/load (sanitised), and registered carry/load_err pulses.
module bcd_counter_ndigit #(
  parameter int DIGITS = 5,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                enable,
  input  logic                up,
  output logic [4*DIGITS-1:0] count,
  output logic                carry,
  output logic                at_max,
  output logic                at_min,
  output logic                load_err
);
  localparam int W = 4*DIGITS;
  logic [W-1:0] count_q, count_d, inc_v, dec_v, load_v;
  logic carry_q, carry_d, load_err_q, load_err_d;
  logic [DIGITS:0] inc_c, dec_c;
  logic [DIGITS-1:0] bad;
  assign inc_c[0] = 1'b1;
  assign dec_c[0] = 1'b1;
  // inc_c[d]/dec_c[d] mean all digits below d are 9/0, so the top bit flags the count limit
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [3:0] q, lv;
    assign q  = count_q[4*d +: 4];
    assign lv = load_value[4*d +: 4];
    assign inc_c[d+1] = inc_c[d] & (q == 4'd9);
    assign dec_c[d+1] = dec_c[d] & (q == 4'd0);
    assign inc_v[4*d +: 4] = inc_c[d] ? ((q == 4'd9) ? 4'd0 : q + 4'd1) : q;
    assign dec_v[4*d +: 4] = dec_c[d] ? ((q == 4'd0) ? 4'd9 : q - 4'd1) : q;
    assign bad[d] = lv > 4'd9;
    assign load_v[4*d +: 4] = bad[d] ? 4'd0 : lv;
  end
  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d    = load_v;
      load_err_d = |bad;
    end else if (enable) begin
      carry_d = up ? inc_c[DIGITS] : dec_c[DIGITS];
      count_d = (carry_d && !WRAP) ? count_q : (up ? inc_v : dec_v);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end
  assign count    = count_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;
  assign at_max   = inc_c[DIGITS];
  assign at_min   = dec_c[DIGITS];
endmodule
